// File: rtl/alu_seq_pkg.sv
// Shared constants for the 16-bit sequencer that drives an external 8-bit ALU.
// Op codes, ALU select codes, FSM states and flag bit positions.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD16 = 3'b000;
    localparam logic [2:0] OP_SUB16 = 3'b001;
    localparam logic [2:0] OP_INX   = 3'b010;
    localparam logic [2:0] OP_DCX   = 3'b011;
    localparam logic [2:0] OP_CMP16 = 3'b100;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_ADDC = 4'b0001;
    localparam logic [3:0] SEL_SUB  = 4'b0010;
    localparam logic [3:0] SEL_SUBC = 4'b0011;
    localparam logic [3:0] SEL_INR  = 4'b1000;
    localparam logic [3:0] SEL_DCR  = 4'b1001;
    localparam logic [3:0] SEL_NOP  = 4'b1111;

    localparam int FLG_PAR = 3;
    localparam int FLG_CY  = 2;
    localparam int FLG_SGN = 1;
    localparam int FLG_ZER = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_CMP16;
    endfunction

    function automatic logic op_incdec(input logic [2:0] op);
        return (op == OP_INX) || (op == OP_DCX);
    endfunction

    function automatic logic [3:0] sel_lo(input logic [2:0] op);
        logic [3:0] s;
        s = SEL_NOP;
        unique case (1'b1)
            op == OP_ADD16: s = SEL_ADD;
            op == OP_SUB16: s = SEL_SUB;
            op == OP_CMP16: s = SEL_SUB;
            op == OP_INX:   s = SEL_INR;
            op == OP_DCX:   s = SEL_DCR;
            default:        s = SEL_NOP;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] sel_hi(input logic [2:0] op);
        logic [3:0] s;
        s = SEL_NOP;
        unique case (1'b1)
            op == OP_ADD16: s = SEL_ADDC;
            op == OP_INX:   s = SEL_ADDC;
            op == OP_SUB16: s = SEL_SUBC;
            op == OP_CMP16: s = SEL_SUBC;
            op == OP_DCX:   s = SEL_SUBC;
            default:        s = SEL_NOP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_seq16.sv
// 16-bit op sequencer: low byte then high byte through an external 8-bit ALU.
// Define ALU_SEQ_ZERO16_EN for a full 16-bit zero flag (default: high-byte zero).
module alu_seq16
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [2:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [15:0] res,
    output logic [3:0]  flags_out,
    output logic        err
);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  op_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic [7:0]  lo_q;
    logic        lo_cy;
    logic        zero16;
    logic        accept;

    assign start_ready = (state == ST_IDLE) && !rst;
    assign done_valid  = (state == ST_DONE);
    assign accept      = start_valid && start_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_cin  = 1'b0;
        alu_sel  = SEL_NOP;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = op_legal(op) ? ST_LO : ST_DONE;
            end
            ST_LO: begin
                alu_a    = opa_q[7:0];
                alu_b    = opb_q[7:0];
                alu_sel  = sel_lo(op_q);
                state_nx = ST_HI;
            end
            ST_HI: begin
                alu_a    = opa_q[15:8];
                alu_b    = op_incdec(op_q) ? 8'h00 : opb_q[15:8];
                alu_cin  = lo_cy;
                alu_sel  = sel_hi(op_q);
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (done_ready) state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_ZERO16_EN
    logic lo_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 lo_z <= 1'b0;
        else if (state == ST_LO) lo_z <= alu_flags[FLG_ZER];
    end

    assign zero16 = lo_z && alu_flags[FLG_ZER];
`else
    assign zero16 = alu_flags[FLG_ZER];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            lo_q      <= '0;
            lo_cy     <= 1'b0;
            res       <= '0;
            flags_out <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        opa_q <= opa;
                        opb_q <= opb;
                        err   <= !op_legal(op);
                        // Illegal ops report straight from IDLE with cleared results
                        if (!op_legal(op)) begin
                            res       <= '0;
                            flags_out <= '0;
                        end
                    end
                end
                ST_LO: begin
                    lo_q  <= alu_result;
                    lo_cy <= alu_flags[FLG_CY];
                end
                ST_HI: begin
                    res <= (op_q == OP_CMP16) ? opa_q
                                              : {alu_result, lo_q};
                    flags_out <= {alu_flags[FLG_PAR],
                                  alu_flags[FLG_CY],
                                  alu_flags[FLG_SGN],
                                  zero16};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: byte-level 8-bit ALU model plus a 16-bit arithmetic
// reference, directed corner cases followed by random operations.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags;
    logic        done_valid;
    logic        done_ready;
    logic [15:0] res;
    logic [3:0]  flags_out;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_seq16 dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .res         (res),
        .flags_out   (flags_out),
        .err         (err)
    );

    // External 8-bit ALU as seen by the sequencer
    always_comb begin
        logic [8:0] t;
        t = 9'h000;
        case (alu_sel)
            4'b0000: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            4'b0010: t = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0011: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
            4'b1000: t = {(alu_a == 8'hFF), alu_a + 8'h01};
            4'b1001: t = {(alu_a == 8'h00), alu_a - 8'h01};
            default: t = 9'h000;
        endcase
        alu_result = t[7:0];
        alu_flags  = {^t[7:0], t[8], t[7], (t[7:0] == 8'h00)};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 16-bit reference from whole-word arithmetic
    function automatic void ref_op(input logic [2:0] o,
                                   input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic [3:0] f,
                                   output logic e, output logic lo_c);
        logic [16:0] s;
        logic [15:0] v;
        logic        z;
        s = '0;
        e = 1'b0;
        lo_c = 1'b0;
        case (o)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                lo_c = (a[7:0] + b[7:0]) > 255;
            end
            3'd1, 3'd4: begin
                s = {1'b0, a} - {1'b0, b};
                lo_c = a[7:0] < b[7:0];
            end
            3'd2: begin
                s = {1'b0, a} + 17'd1;
                lo_c = a[7:0] == 8'hFF;
            end
            3'd3: begin
                s = {1'b0, a} - 17'd1;
                lo_c = a[7:0] == 8'h00;
            end
            default: e = 1'b1;
        endcase
        v = s[15:0];
`ifdef ALU_SEQ_ZERO16_EN
        z = (v == 16'h0000);
`else
        z = (v[15:8] == 8'h00);
`endif
        if (e) begin
            r = '0;
            f = '0;
        end else begin
            r = (o == 3'd4) ? a : v;
            f = {^v[15:8], s[16], v[15], z};
        end
    endfunction

    function automatic logic [3:0] exp_sel(input logic [2:0] o, input bit hi);
        case (o)
            3'd0:    return hi ? 4'b0001 : 4'b0000;
            3'd1:    return hi ? 4'b0011 : 4'b0010;
            3'd4:    return hi ? 4'b0011 : 4'b0010;
            3'd2:    return hi ? 4'b0001 : 4'b1000;
            3'd3:    return hi ? 4'b0011 : 4'b1001;
            default: return 4'b1111;
        endcase
    endfunction

    // One transaction; chain leaves start_valid high across the done handshake
    task automatic run_op(input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int hold, input bit chain);
        logic [15:0] r;
        logic [3:0]  f;
        logic        e;
        logic        lc;
        ref_op(o, a, b, r, f, e, lc);
        @(negedge clk);
        start_valid = 1'b1;
        op = o;
        opa = a;
        opb = b;
        done_ready = 1'b0;
        chk("start_ready_idle", start_ready, 1'b1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op = 3'($urandom);
        opa = 16'($urandom);
        opb = 16'($urandom);
        if (!e) begin
            chk("lo_sel", alu_sel, exp_sel(o, 1'b0));
            chk("lo_a", alu_a, a[7:0]);
            if (o != 3'd2 && o != 3'd3) chk("lo_b", alu_b, b[7:0]);
            chk("lo_cin", alu_cin, 1'b0);
            chk("lo_busy", {start_ready, done_valid}, 2'b00);
            @(posedge clk);
            #1;
            chk("hi_sel", alu_sel, exp_sel(o, 1'b1));
            chk("hi_a", alu_a, a[15:8]);
            chk("hi_b", alu_b, (o == 3'd2 || o == 3'd3) ? 8'h00 : b[15:8]);
            chk("hi_cin", alu_cin, lc);
            chk("hi_busy", {start_ready, done_valid}, 2'b00);
            @(posedge clk);
            #1;
        end
        chk("done_valid", done_valid, 1'b1);
        chk("res", res, r);
        chk("flags", flags_out, f);
        chk("err", err, e);
        chk("done_alu_idle", {alu_sel, alu_a, alu_b, alu_cin},
            {4'b1111, 17'h0});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_state", {done_valid, start_ready}, 2'b10);
            chk("hold_res", {res, flags_out, err}, {r, f, e});
        end
        @(negedge clk);
        done_ready = 1'b1;
        if (chain) begin
            start_valid = 1'b1;
            op = 3'd0;
        end
        chk("no_accept_in_done", start_ready, 1'b0);
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("back_idle", {done_valid, start_ready}, 2'b01);
        chk("idle_alu", alu_sel, 4'b1111);
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        op = '0;
        opa = '0;
        opb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", start_ready, 1'b0);
        chk("rst_done", done_valid, 1'b0);
        chk("rst_outs", {res, flags_out, err}, 21'h0);
        chk("rst_alu", {alu_sel, alu_a, alu_b, alu_cin}, {4'b1111, 17'h0});
        @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 16'h12FF, 16'h0001, 0, 1'b0);
        run_op(3'd1, 16'h0000, 16'h0001, 0, 1'b0);
        run_op(3'd4, 16'h1234, 16'h1234, 1, 1'b0);
        run_op(3'd0, 16'h0001, 16'h0000, 0, 1'b0);
        run_op(3'd2, 16'hFFFF, 16'h5A5A, 0, 1'b0);
        run_op(3'd3, 16'h0000, 16'hA5A5, 0, 1'b0);
        run_op(3'd3, 16'h0100, 16'h0000, 0, 1'b0);
        run_op(3'd0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(3'd7, 16'h1234, 16'h5678, 0, 1'b0);
        run_op(3'd5, 16'hFFFF, 16'hFFFF, 1, 1'b0);
        run_op(3'd1, 16'h8000, 16'h0001, 5, 1'b1);
        run_op(3'd0, 16'h00F0, 16'h0F10, 0, 1'b0);

        // Abort during the high-byte cycle
        @(negedge clk);
        start_valid = 1'b1;
        op = 3'd0;
        opa = 16'hAAAA;
        opb = 16'h5555;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_abort_hi", alu_sel, 4'b0001);
        rst = 1'b1;
        #1;
        chk("abort_state", {start_ready, done_valid}, 2'b00);
        chk("abort_outs", {res, flags_out, err}, 21'h0);
        chk("abort_alu", alu_sel, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done_valid, 1'b0);
        end
        run_op(3'd0, 16'h0102, 16'h0304, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 2), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
